sss_scan: RTL and testbench



---
 rtl/sss_pkg.sv | 9 +
 rtl/sss_scan_if.sv | 10 +
 rtl/sss_seg_decode.sv | 9 +
 rtl/sss_scan.sv | 46 ++++
 tb/tb_sss_scan.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/sss_pkg.sv
// sss_pkg: shared constants and segment lookup for the seven-segment scan path
package sss_pkg;
  localparam int NDIG = 6;
  localparam logic [3:0] BLANK_CODE = 4'd10;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };
endpackage

// File: rtl/sss_scan_if.sv
// sss_scan_if: digit codes in, multiplexed segment/anode bus out
interface sss_scan_if;
  logic [3:0] d0, d1, d2, d3, d4, d5;
  logic [6:0] seg;
  logic dp;
  logic [5:0] an;
  logic frame;
  modport master(output d0, d1, d2, d3, d4, d5, input seg, dp, an, frame);
  modport slave(input d0, d1, d2, d3, d4, d5, output seg, dp, an, frame);
endinterface

// File: rtl/sss_seg_decode.sv
// sss_seg_decode: 4-bit code to active-high g..a segments
module sss_seg_decode
  import sss_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[code];
endmodule

// File: rtl/sss_scan.sv
// sss_scan: frame-snapshotted six-digit scan driver with a blank slot per digit
module sss_scan
  import sss_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW = 1'b1
) (
  input logic clk,
  input logic reset,
  sss_scan_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [5:0] AN_OFF = AN_ACT_LOW ? 6'h3F : 6'h00;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [3:0] sh [NDIG];
  logic [3:0] d [NDIG];
  logic [6:0] seg_hi;
  logic tick, snap;
  assign d = '{bus.d0, bus.d1, bus.d2, bus.d3, bus.d4, bus.d5};
  assign tick = cnt == CW'(SCAN_DIV - 1);
  // The shadow only reloads as the last digit's slot ends, so a frame never mixes old and new digits
  assign snap = tick && idx == 3'(NDIG - 1);
  sss_seg_decode u_dec (.code(sh[idx]), .seg(seg_hi));
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      sh <= '{default: 4'd8};
      bus.an <= AN_OFF;
      bus.seg <= SEG_OFF;
      bus.dp <= SEG_ACT_LOW;
      bus.frame <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= snap ? 3'd0 : idx + 3'd1;
      if (snap) sh <= d;
      bus.an <= cnt == '0 ? AN_OFF : (6'b1 << idx) ^ AN_OFF;
      bus.seg <= cnt == '0 ? SEG_OFF : seg_hi ^ SEG_OFF;
      bus.dp <= SEG_ACT_LOW;
      bus.frame <= snap;
    end
  end
endmodule

// File: tb/tb_sss_scan.sv
// tb_sss_scan: directed checks of reset, scan order, blanking, snapshot, mid-run reset and polarity
module tb_sss_scan;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] d0, d1, d2, d3, d4, d5;
  int checks = 0;
  int failures = 0;
  logic [6:0] scan_tbl [6] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
  logic [6:0] blank_tbl [6] = '{7'h06, 7'h5B, 7'h4F, 7'h00, 7'h6D, 7'h00};
  sss_scan_if ia ();
  sss_scan_if ib ();
  sss_scan_if ic ();
  assign {ia.d5, ia.d4, ia.d3, ia.d2, ia.d1, ia.d0} = {d5, d4, d3, d2, d1, d0};
  assign {ib.d5, ib.d4, ib.d3, ib.d2, ib.d1, ib.d0} = {d5, d4, d3, d2, d1, d0};
  assign {ic.d5, ic.d4, ic.d3, ic.d2, ic.d1, ic.d0} = {d5, d4, d3, d2, d1, d0};
  sss_scan #(.SCAN_DIV(4), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) ua (.clk(clk), .reset(reset), .bus(ia));
  sss_scan #(.SCAN_DIV(4), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b1)) ub (.clk(clk), .reset(reset), .bus(ib));
  sss_scan #(.SCAN_DIV(2), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)) uc (.clk(clk), .reset(reset), .bus(ic));
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] a, b, c, e, f, g);
    {d0, d1, d2, d3, d4, d5} = {a, b, c, e, f, g};
  endtask

  // Leaves the bench #1 after the last reset edge; the next step lands just after E0
  task automatic do_reset;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    set_d(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({ia.an, ia.seg, ia.dp, ia.frame} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL reset_hold c=%0d got an=%h seg=%h dp=%b fr=%b exp an=3f seg=7f dp=1 fr=0", c, ia.an, ia.seg, ia.dp, ia.frame);
      end
    end
    reset = 1'b0;
    step();
    checks++;
    if ({ia.an, ia.seg} !== {6'h3F, 7'h7F}) begin
      failures++;
      $display("FAIL reset_e0 got an=%h seg=%h exp an=3f seg=7f", ia.an, ia.seg);
    end
    step();
    checks++;
    if ({ia.an, ia.seg, ia.frame} !== {6'b111110, 7'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_first_lit got an=%b seg=%h fr=%b exp an=111110 seg=00 fr=0", ia.an, ia.seg, ia.frame);
    end
  endtask

  task automatic test_scan;
    logic [5:0] ea;
    logic [6:0] es;
    int slot;
    set_d(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    do_reset();
    for (int k = 0; k < 52; k++) begin
      step();
      slot = (k / 4) % 6;
      ea = (k % 4 == 0) ? 6'h3F : ~(6'b1 << slot);
      es = (k % 4 == 0) ? 7'h00 : (k < 24) ? 7'h7F : scan_tbl[slot];
      checks++;
      if ({ib.an, ib.seg, ib.dp} !== {ea, es, 1'b0}) begin
        failures++;
        $display("FAIL scan k=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=0", k, ib.an, ib.seg, ib.dp, ea, es);
      end
      checks++;
      if (ib.frame !== (k % 24 == 23)) begin
        failures++;
        $display("FAIL scan_frame k=%0d got=%b exp=%b", k, ib.frame, k % 24 == 23);
      end
    end
  endtask

  task automatic test_blank;
    int slot;
    set_d(4'd1, 4'd2, 4'd3, 4'd10, 4'd5, 4'd15);
    do_reset();
    for (int k = 0; k < 48; k++) begin
      step();
      slot = (k / 4) % 6;
      if (k >= 24 && k % 4 != 0) begin
        checks++;
        if (ib.seg !== blank_tbl[slot] || ia.seg !== ~blank_tbl[slot]) begin
          failures++;
          $display("FAIL blank k=%0d got hi=%h lo=%h exp hi=%h lo=%h", k, ib.seg, ia.seg, blank_tbl[slot], ~blank_tbl[slot]);
        end
      end
    end
  endtask

  task automatic test_snapshot;
    logic [6:0] es;
    int slot;
    set_d(4'd1, 4'd2, 4'd4, 4'd4, 4'd5, 4'd6);
    do_reset();
    for (int k = 0; k < 80; k++) begin
      step();
      slot = (k / 4) % 6;
      if (k == 30) d2 = 4'd9;
      if (k == 70) d0 = 4'd7;
      if (k >= 24 && k % 4 != 0 && (slot == 2 || slot == 0)) begin
        es = slot == 2 ? (k < 48 ? 7'h66 : 7'h6F) : (k < 72 ? 7'h06 : 7'h07);
        checks++;
        if (ib.seg !== es) begin
          failures++;
          $display("FAIL snapshot k=%0d got=%h exp=%h", k, ib.seg, es);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [5:0] ea;
    logic [6:0] es;
    int slot;
    set_d(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    do_reset();
    for (int k = 0; k < 37; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({ia.an, ia.seg, ia.dp, ia.frame} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL midreset_out got an=%h seg=%h dp=%b fr=%b exp an=3f seg=7f dp=1 fr=0", ia.an, ia.seg, ia.dp, ia.frame);
    end
    for (int j = 0; j < 28; j++) begin
      step();
      slot = (j / 4) % 6;
      ea = (j % 4 == 0) ? 6'h3F : ~(6'b1 << slot);
      es = (j % 4 == 0) ? 7'h7F : (j < 24) ? 7'h00 : ~scan_tbl[slot];
      checks++;
      if ({ia.an, ia.seg, ia.frame} !== {ea, es, j == 23}) begin
        failures++;
        $display("FAIL midreset j=%0d got an=%h seg=%h fr=%b exp an=%h seg=%h fr=%b", j, ia.an, ia.seg, ia.frame, ea, es, j == 23);
      end
    end
  endtask

  task automatic test_polarity;
    logic [5:0] ea;
    logic [6:0] es;
    set_d(4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8);
    do_reset();
    for (int k = 0; k < 30; k++) begin
      step();
      ea = (k % 2 == 0) ? 6'h00 : 6'b1 << ((k / 2) % 6);
      es = (k % 2 == 0) ? 7'h00 : 7'h7F;
      checks++;
      if ({ic.an, ic.seg, ic.dp, ic.frame} !== {ea, es, 1'b0, k % 12 == 11}) begin
        failures++;
        $display("FAIL polarity k=%0d got an=%h seg=%h dp=%b fr=%b exp an=%h seg=%h dp=0 fr=%b", k, ic.an, ic.seg, ic.dp, ic.frame, ea, es, k % 12 == 11);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_snapshot();
    test_mid_reset();
    test_polarity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
